// File: rtl/mips_trace_buf_pkg.sv
// mips_trace_pkg: trace entry layout, FSM state encoding and flag bit positions
package mips_trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;
  typedef struct packed {
    logic [9:0]  pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        reg_write;
  } trace_entry_t;
  localparam int FLAG_REGWRITE = 0;
  localparam int FLAG_MEMWRITE = 1;
endpackage

// File: rtl/mips_trace_buf_if.sv
// mips_trace_buf_if: processor-side capture controls and consumer-side trace head/status
interface mips_trace_buf_if #(parameter int DEPTH = 16, parameter int CNT_W = 16);
  logic [9:0]             ip_PC;
  logic [31:0]            ip_instruction;
  logic [31:0]            ip_write_data;
  logic                   ip_RegWrite;
  logic                   ip_MemWrite;
  logic                   ip_stall;
  logic                   ip_capture_en;
  logic                   ip_stop_on_full;
  logic                   ip_clear;
  logic                   ip_ready;
  logic                   op_valid;
  logic [9:0]             op_PC;
  logic [31:0]            op_instruction;
  logic [31:0]            op_write_data;
  logic [1:0]             op_flags;
  logic [$clog2(DEPTH):0] op_level;
  logic [CNT_W-1:0]       op_instr_count;
  logic [CNT_W-1:0]       op_drop_count;
  logic [CNT_W-1:0]       op_stall_cycles;
  logic                   op_overflow;
  logic [1:0]             op_state;
  modport master (
    output ip_PC, ip_instruction, ip_write_data, ip_RegWrite, ip_MemWrite, ip_stall,
           ip_capture_en, ip_stop_on_full, ip_clear, ip_ready,
    input  op_valid, op_PC, op_instruction, op_write_data, op_flags, op_level,
           op_instr_count, op_drop_count, op_stall_cycles, op_overflow, op_state
  );
  modport slave (
    input  ip_PC, ip_instruction, ip_write_data, ip_RegWrite, ip_MemWrite, ip_stall,
           ip_capture_en, ip_stop_on_full, ip_clear, ip_ready,
    output op_valid, op_PC, op_instruction, op_write_data, op_flags, op_level,
           op_instr_count, op_drop_count, op_stall_cycles, op_overflow, op_state
  );
endinterface

// File: rtl/mips_trace_buf_fifo.sv
// trace_fifo: show-ahead circular buffer of trace entries; a push into a full buffer
// is refused unless a pop happens in the same cycle
module trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  trace_entry_t           din_i,
  output trace_entry_t           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  trace_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;
  assign full_o  = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_q];
  assign pop     = pop_i && !empty_o;
  assign push    = push_i && (!full_o || pop);
  always_comb begin
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/mips_trace_buf.sv
// mips_trace_buf: instruction trace capture FSM, saturating counters and trace FIFO.
// Define MIPS_TRACE_STALL_CNT_EN to build the stall-cycle counter.
module mips_trace_buf
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input logic            clock,
  input logic            reset,
  mips_trace_buf_if.slave bus
);
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       instr_q, instr_d, drop_q, drop_d;
  logic                   ovf_q, ovf_d;
  logic                   full, empty, push_req, pop, push, drop;
  logic [$clog2(DEPTH):0] level;
  trace_entry_t           din, head, shown;
  assign push_req = state_q == RUN && !bus.ip_stall && !bus.ip_clear;
  assign pop      = !empty && bus.ip_ready && !bus.ip_clear;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign din      = '{pc: bus.ip_PC, instr: bus.ip_instruction, wdata: bus.ip_write_data,
                      mem_write: bus.ip_MemWrite, reg_write: bus.ip_RegWrite};
  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clock),
    .rst    (!reset || bus.ip_clear),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (din),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );
  always_comb begin
    state_d = bus.ip_clear ? IDLE
            : state_q == IDLE ? (bus.ip_capture_en ? RUN : IDLE)
            : state_q == RUN ? (drop && bus.ip_stop_on_full ? HALT : bus.ip_capture_en ? RUN : IDLE)
            : HALT;
    instr_d = bus.ip_clear ? '0 : (push && !(&instr_q)) ? instr_q + CNT_W'(1) : instr_q;
    drop_d  = bus.ip_clear ? '0 : (drop && !(&drop_q)) ? drop_q + CNT_W'(1) : drop_q;
    ovf_d   = !bus.ip_clear && (ovf_q || drop);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end
`ifdef MIPS_TRACE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  always_comb
    stall_d = bus.ip_clear ? '0
            : (state_q == RUN && bus.ip_stall && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
  always_ff @(posedge clock) begin
    if (!reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign bus.op_stall_cycles = stall_q;
`else
  assign bus.op_stall_cycles = '0;
`endif
  // head fields read as zero while the buffer is empty
  assign shown              = empty ? '0 : head;
  assign bus.op_valid       = !empty;
  assign bus.op_PC          = shown.pc;
  assign bus.op_instruction = shown.instr;
  assign bus.op_write_data  = shown.wdata;
  assign bus.op_flags       = {shown.mem_write, shown.reg_write};
  assign bus.op_level       = level;
  assign bus.op_instr_count = instr_q;
  assign bus.op_drop_count  = drop_q;
  assign bus.op_overflow    = ovf_q;
  assign bus.op_state       = state_q;
endmodule

// File: tb/tb_mips_trace_buf.sv
// tb_mips_trace_buf: directed stimulus with a popped-entry scoreboard for mips_trace_buf
module tb_mips_trace_buf;
  import mips_trace_pkg::*;
`ifdef MIPS_TRACE_STALL_CNT_EN
  localparam int EXP_STALL = 4;
`else
  localparam int EXP_STALL = 0;
`endif
  logic clock, reset;
  int total = 0, bad = 0;
  trace_entry_t exp_q[$];
  trace_entry_t e;
  mips_trace_buf_if bus ();
  mips_trace_buf dut (.clock(clock), .reset(reset), .bus(bus));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic trace_entry_t mk(input logic [9:0] pc);
    mk.pc        = pc;
    mk.instr     = 32'hA000_0000 | {22'h0, pc};
    mk.wdata     = 32'h5000_0000 + {22'h0, pc};
    mk.mem_write = pc[2];
    mk.reg_write = pc[3];
  endfunction

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic [9:0] pc);
    bus.ip_PC          = pc;
    bus.ip_instruction = 32'hA000_0000 | {22'h0, pc};
    bus.ip_write_data  = 32'h5000_0000 + {22'h0, pc};
    bus.ip_MemWrite    = pc[2];
    bus.ip_RegWrite    = pc[3];
  endtask

  task automatic pulse_clear();
    bus.ip_clear = 1'b1;
    step();
    bus.ip_clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_pushes(input int n, input int base);
    bus.ip_capture_en = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      drive(10'(base + 4 * i));
      bus.ip_capture_en = (i != n - 1);
      exp_q.push_back(mk(10'(base + 4 * i)));
      step();
    end
  endtask

  task automatic drain(input int n);
    bus.ip_ready = 1'b1;
    repeat (n) step();
    bus.ip_ready = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset && !bus.ip_clear && bus.op_valid && bus.ip_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 76'(bus.op_PC), 76'h3ff_dead);
      else begin
        e = exp_q.pop_front();
        chk("pop_entry", {bus.op_PC, bus.op_instruction, bus.op_write_data, bus.op_flags}, e);
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.ip_stall = 1'b0;
    bus.ip_capture_en = 1'b0;
    bus.ip_stop_on_full = 1'b0;
    bus.ip_clear = 1'b0;
    bus.ip_ready = 1'b0;
    drive(10'h0);
    step();
    step();
    chk("rst_state", 76'(bus.op_state), 76'(0));
    chk("rst_level", 76'(bus.op_level), 76'(0));
    chk("rst_valid", 76'(bus.op_valid), 76'(0));
    chk("rst_counts", {bus.op_instr_count, bus.op_drop_count, bus.op_stall_cycles, bus.op_overflow}, 76'(0));
    reset = 1'b1;
    // three captured instructions, nothing consumed
    run_pushes(3, 0);
    chk("a_level", 76'(bus.op_level), 76'(3));
    chk("a_head_pc", 76'(bus.op_PC), 76'(0));
    chk("a_instr", 76'(bus.op_instr_count), 76'(3));
    chk("a_state", 76'(bus.op_state), 76'(0));
    drain(3);
    chk("a_empty_level", 76'(bus.op_level), 76'(0));
    chk("a_empty_zero", {bus.op_valid, bus.op_PC, bus.op_instruction, bus.op_write_data}, 76'(0));
    drain(2);
    chk("a_empty_ready", 76'(bus.op_level), 76'(0));
    // overfill without stop_on_full
    pulse_clear();
    chk("b_clr_instr", 76'(bus.op_instr_count), 76'(0));
    bus.ip_capture_en = 1'b1;
    step();
    for (int i = 0; i < 18; i++) begin
      drive(10'(4 * i));
      bus.ip_capture_en = (i != 17);
      if (i < 16) exp_q.push_back(mk(10'(4 * i)));
      step();
      if (i == 16) begin
        chk("b_run_after_drop", 76'(bus.op_state), 76'(1));
        chk("b_drop1", 76'(bus.op_drop_count), 76'(1));
      end
    end
    chk("b_level", 76'(bus.op_level), 76'(16));
    chk("b_drop", 76'(bus.op_drop_count), 76'(2));
    chk("b_ovf", 76'(bus.op_overflow), 76'(1));
    chk("b_instr", 76'(bus.op_instr_count), 76'(16));
    drain(16);
    chk("b_drained", 76'(bus.op_level), 76'(0));
    // overfill with stop_on_full
    pulse_clear();
    bus.ip_stop_on_full = 1'b1;
    bus.ip_capture_en = 1'b1;
    step();
    for (int i = 0; i < 19; i++) begin
      drive(10'(4 * i));
      if (i < 16) exp_q.push_back(mk(10'(4 * i)));
      step();
    end
    chk("c_state_halt", 76'(bus.op_state), 76'(2));
    chk("c_level", 76'(bus.op_level), 76'(16));
    chk("c_drop", 76'(bus.op_drop_count), 76'(1));
    chk("c_instr", 76'(bus.op_instr_count), 76'(16));
    bus.ip_capture_en = 1'b0;
    pulse_clear();
    bus.ip_stop_on_full = 1'b0;
    chk("c_clr_state", 76'(bus.op_state), 76'(0));
    chk("c_clr_level", 76'(bus.op_level), 76'(0));
    chk("c_clr_flags", {bus.op_valid, bus.op_overflow, bus.op_drop_count}, 76'(0));
    // full buffer with simultaneous push and pop
    bus.ip_capture_en = 1'b1;
    step();
    for (int i = 0; i < 21; i++) begin
      drive(10'(4 * i));
      bus.ip_ready = (i >= 16);
      bus.ip_capture_en = (i != 20);
      exp_q.push_back(mk(10'(4 * i)));
      step();
    end
    bus.ip_ready = 1'b0;
    chk("d_level", 76'(bus.op_level), 76'(16));
    chk("d_drop", 76'(bus.op_drop_count), 76'(0));
    chk("d_instr", 76'(bus.op_instr_count), 76'(21));
    chk("d_head_pc", 76'(bus.op_PC), 76'(20));
    drain(16);
    chk("d_drained", 76'(bus.op_level), 76'(0));
    chk("d_sb_empty", 76'(exp_q.size()), 76'(0));
    // stalled capture
    pulse_clear();
    bus.ip_capture_en = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.ip_stall = 1'b1;
      bus.ip_capture_en = (i != 3);
      step();
    end
    bus.ip_stall = 1'b0;
    chk("e_level", 76'(bus.op_level), 76'(0));
    chk("e_instr", 76'(bus.op_instr_count), 76'(0));
    chk("e_stall", 76'(bus.op_stall_cycles), 76'(EXP_STALL));
    // reset colliding with push, pop and clear
    run_pushes(7, 10'h200);
    chk("f_level", 76'(bus.op_level), 76'(7));
    bus.ip_capture_en = 1'b1;
    step();
    drive(10'h3f0);
    reset = 1'b0;
    bus.ip_ready = 1'b1;
    bus.ip_clear = 1'b1;
    step();
    exp_q.delete();
    reset = 1'b1;
    bus.ip_ready = 1'b0;
    bus.ip_clear = 1'b0;
    bus.ip_capture_en = 1'b0;
    chk("f_level", 76'(bus.op_level), 76'(0));
    chk("f_valid", 76'(bus.op_valid), 76'(0));
    chk("f_state", 76'(bus.op_state), 76'(0));
    chk("f_counts", {bus.op_instr_count, bus.op_drop_count, bus.op_stall_cycles, bus.op_overflow}, 76'(0));
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
